// File: rtl/set_assoc_cache.sv
// set_assoc_cache: write-back set-associative cache with round-robin replacement and a beat-serial memory port
// Ports: clk, rst_n (async active-low); load/store/address/data_in CPU request;
//        hit/miss/busy/data_out CPU status and load data;
//        mem_read/mem_write/mem_addr/mem_write_data/mem_data/mem_ready single-word memory beats.
module set_assoc_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SET_WIDTH = 4,
    parameter int WAYS = 4,
    parameter int LINE_WORDS = 4,
    parameter bit WRITE_ALLOCATE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  store,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  hit,
    output logic                  miss,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int OW = OB > 0 ? OB : 1;
    localparam int WW = $clog2(WAYS);
    localparam int SETS = 1 << SET_WIDTH;
    localparam int LSB = OB + 2;
    localparam int TW = DATA_WIDTH - LSB - SET_WIDTH;

    typedef enum logic [2:0] {IDLE, WRITE_BACK, REFILL, WRITE_AROUND, UPDATE} state_t;
    state_t state, next_state;

    logic [DATA_WIDTH-1:0] lines [SETS][WAYS][LINE_WORDS];
    logic [TW-1:0]         tags [SETS][WAYS];
    logic [WAYS-1:0]       valid [SETS];
    logic [WAYS-1:0]       dirty [SETS];
    logic [WW-1:0]         rr [SETS];
    logic [DATA_WIDTH-1:0] line_buf [LINE_WORDS];

    logic [DATA_WIDTH-1:0] word_addr, line_base, wb_base, beat_off;
    logic [OW-1:0]         offset, beat;
    logic [SET_WIDTH-1:0]  index;
    logic [TW-1:0]         tag;
    logic [WW-1:0]         hit_way, free_way, pick_way, victim;
    logic                  has_free, store_q, last_beat, beat_done, victim_dirty;

    assign word_addr = address >> 2;
    assign offset = OW'(word_addr) & OW'(LINE_WORDS - 1);
    assign index = SET_WIDTH'(address >> LSB);
    assign tag = TW'(address >> (LSB + SET_WIDTH));

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (valid[index][w] && tags[index][w] == tag) begin
                hit = 1'b1;
                hit_way = WW'(w);
            end
    end

    // Descending scan leaves the lowest-numbered invalid way selected.
    always_comb begin
        has_free = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[index][w]) begin
                has_free = 1'b1;
                free_way = WW'(w);
            end
    end

    assign pick_way = has_free ? free_way : rr[index];
    assign victim_dirty = valid[index][pick_way] && dirty[index][pick_way];
    assign miss = !hit && (load || store) && state == IDLE;
    assign data_out = lines[index][hit_way][offset];
    assign last_beat = beat == OW'(LINE_WORDS - 1);
    assign beat_done = mem_ready && (state == WRITE_BACK || state == REFILL);

    assign beat_off = DATA_WIDTH'(beat) << 2;
    assign line_base = (address >> LSB) << LSB;
    assign wb_base = DATA_WIDTH'({tags[index][victim], index}) << LSB;
    assign mem_addr = state == WRITE_AROUND ? {address[DATA_WIDTH-1:2], 2'b00}
                    : (state == WRITE_BACK ? wb_base : line_base) | beat_off;
    assign mem_write_data = state == WRITE_AROUND ? data_in : lines[index][victim][beat];

    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (miss) next_state = victim_dirty ? WRITE_BACK
                                               : (!store || WRITE_ALLOCATE) ? REFILL : WRITE_AROUND;
            WRITE_BACK:   if (beat_done && last_beat)
                              next_state = (!store_q || WRITE_ALLOCATE) ? REFILL : WRITE_AROUND;
            REFILL:       if (beat_done && last_beat) next_state = UPDATE;
            WRITE_AROUND: if (mem_ready) next_state = IDLE;
            UPDATE:       next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    // Status and strobes are registered from next_state so they drop on the edge taking the final beat.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            beat <= '0;
            victim <= '0;
            store_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                rr[s] <= '0;
            end
        end else begin
            state <= next_state;
            busy <= next_state != IDLE;
            mem_read <= next_state == REFILL;
            mem_write <= next_state == WRITE_BACK || next_state == WRITE_AROUND;
            if (miss) begin
                victim <= pick_way;
                store_q <= store;
            end
            if (beat_done) beat <= last_beat ? '0 : beat + 1'b1;
            if (state == IDLE && store && hit) dirty[index][hit_way] <= 1'b1;
            if (state == WRITE_BACK && beat_done && last_beat) dirty[index][victim] <= 1'b0;
            if (state == UPDATE) begin
                valid[index][victim] <= 1'b1;
                dirty[index][victim] <= store_q;
                rr[index] <= rr[index] + 1'b1;
            end
        end

    always_ff @(posedge clk) begin
        if (state == IDLE && store && hit) lines[index][hit_way][offset] <= data_in;
        if (state == REFILL && mem_ready) line_buf[beat] <= mem_data;
        if (state == UPDATE) begin
            tags[index][victim] <= tag;
            for (int w = 0; w < LINE_WORDS; w++)
                lines[index][victim][w] <= (store_q && OW'(w) == offset) ? data_in : line_buf[w];
        end
    end
endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of CPU word and address.
REQ-002 Parameter SET_WIDTH, default 4, log2 of set count.
REQ-003 Parameter WAYS, default 4, associativity; power of two, at least 2.
REQ-004 Parameter LINE_WORDS, default 4, words per line; power of two, at least 1.
REQ-005 Parameter WRITE_ALLOCATE, default 1, where 1 allocates on store miss and 0 writes around.
REQ-006 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Ports load and store, inputs, 1 each, CPU request strobes; store has priority if both are high.
REQ-009 Ports address and data_in, inputs, DATA_WIDTH each, byte address (bits [1:0] ignored) and store data.
REQ-010 Ports hit, miss and busy, outputs, 1 each, status lines.
REQ-011 Port data_out, output, DATA_WIDTH, load data.
REQ-012 Ports mem_read and mem_write, outputs, 1 each, memory beat request strobes.
REQ-013 Port mem_addr, output, DATA_WIDTH, word-aligned byte address of the current beat.
REQ-014 Port mem_write_data, output, DATA_WIDTH, write beat data.
REQ-015 Port mem_data, input, DATA_WIDTH, read beat data; valid when mem_ready is high.
REQ-016 Port mem_ready, input, 1, completes the current beat.

Function
REQ-017 Address split SHALL be: word offset = address[log2(LINE_WORDS)+1:2]; index = next SET_WIDTH bits; tag = remaining upper bits.
REQ-018 hit SHALL be combinational: any valid way in the indexed set has a matching tag; miss = !hit && (load || store) while in IDLE.
REQ-019 On a load hit, data_out SHALL present the addressed word in the same cycle.
REQ-020 On a store hit, the addressed word and the line dirty bit SHALL update at the next edge.
REQ-021 Victim way SHALL be the lowest-numbered invalid way; if all ways are valid, the victim is the per-set round-robin pointer.
REQ-022 The round-robin pointer SHALL advance by one, modulo WAYS, only when a line is filled.
REQ-023 FSM states SHALL be IDLE, WRITE_BACK, REFILL, WRITE_AROUND and UPDATE.
REQ-024 IDLE with miss: busy rises at the next edge. If the victim is valid and dirty, go to WRITE_BACK; else if load or WRITE_ALLOCATE=1, go to REFILL; else go to WRITE_AROUND.
REQ-025 WRITE_BACK SHALL send LINE_WORDS beats, word 0 first, at victim-tag line address + 4*beat, with mem_write high throughout.
REQ-026 Each WRITE_BACK beat advances on mem_ready; after the last beat, go to REFILL or WRITE_AROUND per REQ-024.
REQ-027 REFILL SHALL request LINE_WORDS beats at the requested line base + 4*beat with mem_read high; each beat is captured into the line buffer on mem_ready; after the last beat, go to UPDATE.
REQ-028 WRITE_AROUND SHALL drive one beat: mem_write high, mem_addr = address, mem_write_data = data_in; on mem_ready, clear busy and return to IDLE with no line change.
REQ-029 UPDATE SHALL install the line buffer in the victim way with valid=1 and tag set.
REQ-030 In UPDATE, a store SHALL merge data_in into the addressed word and set dirty=1; a load sets dirty=0.
REQ-031 UPDATE SHALL deassert busy and return to IDLE; the held request then hits.
REQ-032 Memory beat strobes SHALL be registered and drop in the same edge that accepts the final beat; mem_ready outside a burst state is ignored.
REQ-033 While busy is high, load, store, address and data_in SHALL be held stable by the CPU; the cache does not re-sample the request type mid-miss.
REQ-034 Miss latency: a clean load miss is LINE_WORDS+1 cycles plus memory wait cycles; a dirty load miss is 2*LINE_WORDS+1 cycles plus memory wait cycles.

Reset
REQ-035 On rst_n low, state SHALL be IDLE; busy, mem_read and mem_write are 0; all valid and dirty bits and round-robin pointers are 0; the beat counter is 0.
REQ-036 Reset asserted mid-burst SHALL abort the burst immediately; no partial line is installed.

Verification
REQ-037 Load 0x100 from cold with mem_ready tied high -> busy for 5 cycles, 4 reads at 0x100..0x10C, then hit=1 with the correct data_out.
REQ-038 Fill all 4 ways of set 0, then load a 5th tag -> way 0 replaced, then way 1 on the next conflict.
REQ-039 Store hit to 0x104 with 0xDEADBEEF, then evict that line -> 4 write beats from 0x100, beat 1 = 0xDEADBEEF, then the refill follows.
REQ-040 WRITE_ALLOCATE=0, store miss to 0x200 -> a single mem_write beat at 0x200 and no line is allocated; a following load to 0x200 misses.
REQ-041 Assert rst_n low during refill beat 2 -> strobes drop asynchronously, and a later load to the same line misses.
REQ-042 Hold mem_ready low for 3 cycles on each beat -> the beat address and strobe stay stable, and the data is correct after completion.
